// File: rtl/const_table_arbiter.sv
// const_table_arbiter: round-robin arbiter serving constant-table lookups with a held response handshake
//   clock, reset_n     : rising-edge clock, asynchronous active-low reset
//   req, sel           : per-requester request and 2-bit table index (sel[2i+1:2i])
//   req_ack            : one-hot grant pulse during the lookup cycle
//   resp_valid/ready   : response handshake carrying resp_data, resp_id, resp_err
//   served_count       : completed responses, wraps modulo 256
module const_table_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [2*NUM_REQ-1:0] sel,
    output logic [NUM_REQ-1:0]   req_ack,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [DATA_W-1:0]    resp_data,
    output logic [1:0]           resp_id,
    output logic                 resp_err,
    output logic [7:0]           served_count
);
    localparam int CONST_A = 10;
    localparam int CONST_B = 20;
    localparam logic [DATA_W-1:0] VAL_0 = DATA_W'(CONST_A);
    localparam logic [DATA_W-1:0] VAL_1 = DATA_W'(CONST_B);
    localparam logic [DATA_W-1:0] VAL_2 = DATA_W'(CONST_A + CONST_B + 7);

    typedef enum logic [1:0] {IDLE, LOOKUP, RESP} state_t;
    state_t state, state_next;

    logic [1:0]        ptr, win, win_id, win_sel;
    logic [DATA_W-1:0] lut;
    logic              grant;

    // scan downward so the lowest offset from ptr is the last (winning) assignment
    always_comb begin
        win = ptr;
        for (int k = NUM_REQ - 1; k >= 0; k--)
            if (req[ptr + 2'(k)]) win = ptr + 2'(k);
    end

    assign grant = (state == IDLE) && |req;
    assign lut   = win_sel == 2'd0 ? VAL_0 : win_sel == 2'd1 ? VAL_1 : win_sel == 2'd2 ? VAL_2 : '0;

    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) state <= IDLE;
        else          state <= state_next;

    always_comb begin
        state_next = state;
        req_ack    = '0;
        resp_valid = 1'b0;
        state_next = grant ? LOOKUP :
                     state == LOOKUP ? RESP :
                     (state == RESP && resp_ready) ? IDLE : state;
        req_ack    = state == LOOKUP ? NUM_REQ'(1) << win_id : '0;
        resp_valid = state == RESP;
    end

    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) begin
            ptr          <= '0;
            win_id       <= '0;
            win_sel      <= '0;
            resp_data    <= '0;
            resp_id      <= '0;
            resp_err     <= 1'b0;
            served_count <= '0;
        end else begin
            if (grant) begin
                win_id  <= win;
                win_sel <= sel[{win, 1'b0} +: 2];
                ptr     <= win + 2'd1;
            end
            if (state == LOOKUP) begin
                resp_data <= lut;
                resp_id   <= win_id;
                resp_err  <= &win_sel;
            end
            if (state == RESP && resp_ready) served_count <= served_count + 8'd1;
        end
endmodule

// File: tb/tb_const_table_arbiter.sv
// tb_const_table_arbiter: scoreboard bench for const_table_arbiter with directed vectors
module tb_const_table_arbiter;
    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] req = '0;
    logic [7:0] sel = '0;
    logic [3:0] req_ack;
    logic       resp_valid;
    logic       resp_ready = 1'b1;
    logic [7:0] resp_data;
    logic [1:0] resp_id;
    logic       resp_err;
    logic [7:0] served_count;

    typedef struct {
        logic [7:0] d;
        logic [1:0] id;
        logic       e;
    } rsp_t;

    rsp_t       rsp_q[$];
    logic [3:0] ack_q[$];
    int         compared = 0;
    int         mismatched = 0;

    const_table_arbiter #(.NUM_REQ(4), .DATA_W(8)) dut (
        .clock(clock), .reset_n(reset_n), .req(req), .sel(sel), .req_ack(req_ack),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .resp_id(resp_id), .resp_err(resp_err), .served_count(served_count)
    );

    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] tv(input int s);
        return s == 0 ? 8'd10 : s == 1 ? 8'd20 : s == 2 ? 8'd37 : 8'd0;
    endfunction

    always @(negedge clock) begin
        if (req_ack != 4'b0) begin
            if (ack_q.size() == 0) chk("ack_unexpected", {28'b0, req_ack}, 32'd0);
            else chk("ack", {28'b0, req_ack}, {28'b0, ack_q.pop_front()});
        end
        if (resp_valid && resp_ready) begin
            if (rsp_q.size() == 0) chk("resp_unexpected", 32'd1, 32'd0);
            else begin
                rsp_t r;
                r = rsp_q.pop_front();
                chk("resp", {21'b0, resp_data, resp_id, resp_err}, {21'b0, r.d, r.id, r.e});
            end
        end
    end

    task automatic wait_acks(input int n);
        int c = 0;
        for (int t = 0; t < 200 && c < n; t++) begin
            @(posedge clock); #1;
            if (req_ack != 4'b0) c++;
        end
        if (c < n) chk("ack_timeout", c, n);
    endtask

    task automatic wait_drain();
        int t = 0;
        while (rsp_q.size() != 0 && t < 200) begin
            @(posedge clock); #1;
            t++;
        end
        if (rsp_q.size() != 0) chk("drain_timeout", rsp_q.size(), 0);
        @(posedge clock); #1;
    endtask

    task automatic push(input logic [1:0] id, input logic [7:0] d, input logic e);
        rsp_t r;
        r.d = d; r.id = id; r.e = e;
        ack_q.push_back(4'b1 << id);
        rsp_q.push_back(r);
    endtask

    task automatic do_txn(input logic [1:0] id, input int s, input logic [7:0] d, input logic e);
        push(id, d, e);
        sel = 8'(s) << (2 * id);
        req = 4'b1 << id;
        wait_acks(1);
        req = '0;
        wait_drain();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        @(posedge clock); #1;
        chk("rst_valid", resp_valid, 0);
        chk("rst_ack", req_ack, 0);
        chk("rst_count", served_count, 0);
        #3 reset_n = 1'b1;

        // case 1: single request, index 2 -> 37
        do_txn(2'd0, 2, 8'd37, 1'b0);
        chk("c1_count", served_count, 1);

        // reset so the pointer restarts at 0 for the fairness sweep
        #2 reset_n = 1'b0;
        #1 chk("c2_rst_count", served_count, 0);
        #2 reset_n = 1'b1;

        // case 2: all requesting, order 0,1,2,3,0
        sel = 8'h00;
        push(2'd0, 8'd10, 1'b0);
        push(2'd1, 8'd10, 1'b0);
        push(2'd2, 8'd10, 1'b0);
        push(2'd3, 8'd10, 1'b0);
        push(2'd0, 8'd10, 1'b0);
        @(posedge clock); #1;
        req = 4'b1111;
        wait_acks(5);
        req = '0;
        wait_drain();
        chk("c2_count", served_count, 5);

        // case 3: invalid index
        do_txn(2'd2, 3, 8'd0, 1'b1);
        chk("c3_count", served_count, 6);

        // case 4: backpressure, sel churn, request queued during RESP
        resp_ready = 1'b0;
        push(2'd1, 8'd20, 1'b0);
        sel = 8'b0000_0100;
        req = 4'b0010;
        wait_acks(1);
        req = '0;
        @(posedge clock); #1;
        req = 4'b1000;
        for (int i = 0; i < 5; i++) begin
            sel = 8'($urandom);
            @(posedge clock); #1;
            chk("c4_valid", resp_valid, 1);
            chk("c4_data", resp_data, 20);
            chk("c4_id", resp_id, 1);
            chk("c4_noack", req_ack, 0);
            chk("c4_count", served_count, 6);
        end
        sel = 8'h00;
        push(2'd3, 8'd10, 1'b0);
        resp_ready = 1'b1;
        wait_acks(1);
        req = '0;
        wait_drain();
        chk("c4_count_end", served_count, 8);

        // case 5: asynchronous reset mid-RESP aborts the transaction
        resp_ready = 1'b0;
        ack_q.push_back(4'b0001);
        sel = 8'h00;
        req = 4'b0001;
        wait_acks(1);
        req = '0;
        @(posedge clock); #1;
        chk("c5_in_resp", resp_valid, 1);
        #1 reset_n = 1'b0;
        #1;
        chk("c5_valid", resp_valid, 0);
        chk("c5_data", resp_data, 0);
        chk("c5_id", resp_id, 0);
        chk("c5_err", resp_err, 0);
        chk("c5_ack", req_ack, 0);
        chk("c5_count", served_count, 0);
        repeat (2) @(posedge clock);
        #3 reset_n = 1'b1;
        resp_ready = 1'b1;
        do_txn(2'd3, 0, 8'd10, 1'b0);
        chk("c5_count_end", served_count, 1);

        // case 6: wrap of served_count
        for (int i = 0; i < 254; i++) do_txn(2'(i % 4), i % 4, tv(i % 4), (i % 4) == 3);
        chk("c6_count_255", served_count, 255);
        do_txn(2'd1, 1, 8'd20, 1'b0);
        chk("c6_wrap", served_count, 0);
        chk("c6_queues_empty", ack_q.size() + rsp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/const_table_arbiter.md
CONST_TABLE_ARBITER -- requirements
Module: const_table_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters; this revision supports only 4.
REQ-002 SHALL have parameter DATA_W, default 8, width of returned constant.
REQ-003 SHALL have port clock  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port req  input  4  per-requester request; held high until that requester's ack.
REQ-006 SHALL have port sel  input  8  constant index per requester: sel[2i+1:2i] for requester i.
REQ-007 SHALL have port req_ack  output  4  one-hot, one-cycle grant acknowledge.
REQ-008 SHALL have port resp_valid  output  1  response held valid.
REQ-009 SHALL have port resp_ready  input  1  consumer accepts response.
REQ-010 SHALL have port resp_data  output  8  looked-up constant.
REQ-011 SHALL have port resp_id  output  2  index of the served requester.
REQ-012 SHALL have port resp_err  output  1  invalid index requested.
REQ-013 SHALL have port served_count  output  8  count of completed responses.

Function
REQ-014 SHALL hold a fixed table: index 0 -> 10 (CONST_A), 1 -> 20 (CONST_B), 2 -> 37 (CONST_A + CONST_B + 7), 3 -> invalid.
REQ-015 SHALL compute index 2 from the same constant definitions as indices 0 and 1, not from a literal; result SHALL be truncated to DATA_W bits.
REQ-016 SHALL implement FSM states IDLE, LOOKUP, RESP; state SHALL be IDLE out of reset.
REQ-017 SHALL stay in IDLE while req == 0.
REQ-018 In IDLE with any req bit set at a rising edge, SHALL register the winner id and its sel and enter LOOKUP.
REQ-019 SHALL pick the winner round-robin: first set req bit searching upward from pointer ptr, wrapping 3 -> 0.
REQ-020 SHALL set ptr = (winner + 1) mod 4 on every grant.
REQ-021 SHALL assert req_ack[winner] for exactly the LOOKUP cycle; all other req_ack bits SHALL be 0.
REQ-022 LOOKUP SHALL always advance to RESP on the next edge, registering resp_data, resp_id and resp_err.
REQ-023 For index 3, resp_err SHALL be 1 and resp_data SHALL be 0; otherwise resp_err SHALL be 0.
REQ-024 In RESP, resp_valid SHALL be 1 and resp_data, resp_id and resp_err SHALL stay stable until the handshake.
REQ-025 In RESP with resp_ready == 1 at an edge, SHALL return to IDLE and increment served_count.
REQ-026 served_count SHALL wrap modulo 256 (255 -> 0).
REQ-027 resp_valid SHALL be 0 in IDLE and LOOKUP.
REQ-028 Requests arriving in LOOKUP or RESP SHALL wait, are not lost, and SHALL be arbitrated in the next IDLE.
REQ-029 Latency SHALL be: resp_valid is first high in the second cycle after the sampling edge.
REQ-030 Throughput SHALL be at most one transaction per 3 cycles.
REQ-031 A req bit still high in IDLE after its ack SHALL be treated as a new request.
REQ-032 sel SHALL be sampled only at the grant edge; later sel changes SHALL NOT affect the response.

Reset
REQ-033 reset_n low SHALL asynchronously force: state = IDLE, ptr = 0, req_ack = 0, resp_valid = 0, resp_data = 0, resp_id = 0, resp_err = 0, served_count = 0.
REQ-034 Reset during LOOKUP or RESP SHALL abort the transaction with no response and no served_count increment.
REQ-035 After reset_n rises, the first grant SHALL occur no earlier than the first rising edge with reset_n high.

Verification
REQ-036 Case 1: req = 0001, sel[1:0] = 2, resp_ready = 1 -> req_ack = 0001 for one cycle; resp_valid one cycle later with data 37, id 0, err 0; served_count = 1.
REQ-037 Case 2: req = 1111 held, all sels = 0, resp_ready = 1 -> grant order 0, 1, 2, 3, 0; each response data = 10.
REQ-038 Case 3: req = 0100 with sel = 3 -> resp_err = 1, resp_data = 0, resp_id = 2.
REQ-039 Case 4: hold resp_ready = 0 for 5 cycles in RESP while sel changes -> resp_valid and resp_data stay constant, no new ack, served_count unchanged.
REQ-040 Case 5: assert reset_n low mid-RESP -> all outputs 0 immediately (asynchronous); after release, req = 1000 gives resp_id 3 (ptr = 0 search).
REQ-041 Case 6: complete 256 transactions -> served_count wraps to 0.
